// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: receive-side byte handshake between the UART receiver
// (master, produces bytes and status pulses) and its consumer (slave,
// acknowledges bytes with rd_en).
interface uart_rx_core_if;
   logic       rd_en;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      output data_out,
      output rx_valid,
      output frame_err,
      output overrun,
      output busy,
      input  rd_en
   );

   modport slave (
      input  data_out,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      input  busy,
      output rd_en
   );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver. The rx pin is synchronized, the start bit
// is validated at mid-bit, eight data bits are sampled LSB-first and the stop
// bit is checked. A good byte lands in a holding register with a valid/read
// handshake; framing and overrun errors are reported as one-cycle pulses.
// Optional feature macro: UART_RX_MAJORITY_EN selects a 2-of-3 majority vote
// around mid-bit for every start/data/stop decision (decisions one cycle later).
module uart_rx_core #(
   parameter int unsigned CLKS_PER_BIT = 10416
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx,
   uart_rx_core_if.master    bus
);

   localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [15:0] START_DEC = 16'(HALF + 1);
   localparam logic [15:0] START_A   = 16'(HALF - 1);
   localparam logic [15:0] START_B   = 16'(HALF);
   localparam logic [15:0] BIT_A     = 16'(CLKS_PER_BIT - 3);
   localparam logic [15:0] BIT_B     = 16'(CLKS_PER_BIT - 2);
`else
   localparam logic [15:0] START_DEC = 16'(HALF);
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t      state_r, state_n;
   logic        sync1_r, sync2_r;
   logic        rx_s;
   logic        bit_s;
   logic [15:0] cnt_r, cnt_n;
   logic [2:0]  idx_r, idx_n;
   logic [7:0]  shift_r, shift_n;
   logic [7:0]  data_r, data_n;
   logic        valid_r, valid_n;
   logic        fe_r, fe_n;
   logic        ov_r, ov_n;
   logic        busy_r, busy_n;

   assign rx_s = sync2_r;

   // Two-flop synchronizer for the asynchronous rx line (idles high).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rx;
         sync2_r <= sync1_r;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic samp_a_r, samp_b_r;

   // 2-of-3 majority vote of the three mid-bit samples.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Capture the first two of the three mid-bit samples; the third is rx_s
   // itself on the decision edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samp_a_r <= 1'b1;
         samp_b_r <= 1'b1;
      end else if (state_r == START) begin
         if (cnt_r == START_A) samp_a_r <= rx_s;
         if (cnt_r == START_B) samp_b_r <= rx_s;
      end else if ((state_r == DATA) || (state_r == STOP)) begin
         if (cnt_r == BIT_A) samp_a_r <= rx_s;
         if (cnt_r == BIT_B) samp_b_r <= rx_s;
      end
   end

   assign bit_s = maj3(samp_a_r, samp_b_r, rx_s);
`else
   assign bit_s = rx_s;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic plus next values for counters, shifter and outputs.
   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      idx_n   = idx_r;
      shift_n = shift_r;
      data_n  = data_r;
      fe_n    = 1'b0;
      ov_n    = 1'b0;
      // Consumer acknowledge; a completing byte below overrides this.
      if (bus.rd_en && valid_r) begin
         valid_n = 1'b0;
      end else begin
         valid_n = valid_r;
      end

      case (state_r)
         IDLE: begin
            cnt_n = 16'd0;
            if (!rx_s) begin
               state_n = START;
            end else begin
               state_n = IDLE;
            end
         end
         START: begin
            if (cnt_r == START_DEC) begin
               cnt_n = 16'd0;
               if (!bit_s) begin
                  state_n = DATA;
                  idx_n   = 3'd0;
               end else begin
                  // Start bit did not hold: treat as a glitch.
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt_r + 16'd1;
            end
         end
         DATA: begin
            if (cnt_r == BIT_LAST) begin
               cnt_n   = 16'd0;
               shift_n = {bit_s, shift_r[7:1]};
               idx_n   = idx_r + 3'd1;
               if (idx_r == 3'd7) begin
                  state_n = STOP;
               end else begin
                  state_n = DATA;
               end
            end else begin
               cnt_n = cnt_r + 16'd1;
            end
         end
         STOP: begin
            if (cnt_r == BIT_LAST) begin
               cnt_n = 16'd0;
               if (bit_s) begin
                  data_n  = shift_r;
                  // An unread byte being replaced is an overrun unless it is
                  // being acknowledged on this very edge.
                  ov_n    = valid_r && !bus.rd_en;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  fe_n    = 1'b1;
                  state_n = WAIT_HIGH;
               end
            end else begin
               cnt_n = cnt_r + 16'd1;
            end
         end
         WAIT_HIGH: begin
            // Hold off until the line returns high so a break reports once.
            if (rx_s) begin
               state_n = IDLE;
            end else begin
               state_n = WAIT_HIGH;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 16'd0;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r   <= 16'd0;
         idx_r   <= 3'd0;
         shift_r <= 8'h00;
         data_r  <= 8'h00;
         valid_r <= 1'b0;
         fe_r    <= 1'b0;
         ov_r    <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         cnt_r   <= cnt_n;
         idx_r   <= idx_n;
         shift_r <= shift_n;
         data_r  <= data_n;
         valid_r <= valid_n;
         fe_r    <= fe_n;
         ov_r    <= ov_n;
         busy_r  <= busy_n;
      end
   end

   assign bus.data_out  = data_r;
   assign bus.rx_valid  = valid_r;
   assign bus.frame_err = fe_r;
   assign bus.overrun   = ov_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core at 16 clk/bit.
// rx and rd_en change on falling edges; outputs are observed on falling edges.
module tb_uart_rx_core;

   localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int STOP_EDGE = 155;   // E0 + 2 + HALF + 1 + 9*CPB + 1
`else
   localparam int STOP_EDGE = 154;   // E0 + 2 + HALF + 1 + 9*CPB
`endif

   logic clk;
   logic reset_n;
   logic rx;
   logic rd_en;

   int checks;
   int errors;

   // Per-frame observations, posedge index relative to E0 (-1 = never).
   int valid_rise_at;
   int fe_at;
   int ov_at;
   int fe_cnt;
   int ov_cnt;

   uart_rx_core_if bus ();
   assign bus.rd_en = rd_en;

   uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx),
      .bus     (bus)
   );

   // 10 ns system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one full 10-bit frame starting at the current falling edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int rd_at, input logic spike);
      int   idx;
      logic v;
      logic prev_valid;
      valid_rise_at = -1;
      fe_at = -1;
      ov_at = -1;
      fe_cnt = 0;
      ov_cnt = 0;
      prev_valid = bus.rx_valid;
      for (int c = 0; c < 10 * CPB; c++) begin
         idx = c / CPB;
         if (idx == 0) v = 1'b0;
         else if (idx == 9) v = stop_bit;
         else v = b[idx - 1];
         if (spike && (idx >= 1) && (idx <= 8) && ((c % CPB) == 8)) v = ~v;
         rx = v;
         rd_en = (c == rd_at);
         @(negedge clk);
         if (bus.rx_valid && !prev_valid && (valid_rise_at < 0)) valid_rise_at = c;
         prev_valid = bus.rx_valid;
         if (bus.frame_err) begin
            fe_cnt++;
            if (fe_at < 0) fe_at = c;
         end
         if (bus.overrun) begin
            ov_cnt++;
            if (ov_at < 0) ov_at = c;
         end
      end
      rd_en = 1'b0;
      rx = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_read();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rx = 1'b1;
      rd_en = 1'b0;
      idle_cycles(3);
      reset_n = 1'b1;
      idle_cycles(3);
      checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b want 0", bus.frame_err); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", bus.overrun); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b1, -1, 1'b0);
      checks++; if (valid_rise_at != STOP_EDGE) begin errors++; $display("FAIL a5_timing: got %0d want %0d", valid_rise_at, STOP_EDGE); end
      checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", bus.data_out); end
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL a5_valid: got %b want 1", bus.rx_valid); end
      checks++; if (fe_cnt != 0) begin errors++; $display("FAIL a5_fe: got %0d want 0", fe_cnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL a5_busy_idle: got %b want 0", bus.busy); end
      do_read();
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL a5_read_clear: got %b want 0", bus.rx_valid); end
   endtask

   task automatic test_glitch();
      int rises;
      int fes;
      rises = 0;
      fes = 0;
      for (int c = 0; c < 40; c++) begin
         rx = (c < 4) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (bus.rx_valid) rises++;
         if (bus.frame_err) fes++;
         if (c == 3) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", bus.busy); end
         end
         if (c == 20) begin
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %b want 0", bus.busy); end
         end
      end
      checks++; if (rises != 0) begin errors++; $display("FAIL glitch_valid: got %0d cycles want 0", rises); end
      checks++; if (fes != 0) begin errors++; $display("FAIL glitch_fe: got %0d want 0", fes); end
   endtask

   task automatic test_frame_err();
      int total_fe;
      send_frame(8'h3C, 1'b0, -1, 1'b0);
      total_fe = fe_cnt;
      checks++; if (fe_at != STOP_EDGE) begin errors++; $display("FAIL fe_timing: got %0d want %0d", fe_at, STOP_EDGE); end
      rx = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.frame_err) total_fe++;
      end
      rx = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.frame_err) total_fe++;
      end
      checks++; if (total_fe != 1) begin errors++; $display("FAIL fe_count: got %0d want 1", total_fe); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL fe_valid: got %b want 0", bus.rx_valid); end
      checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL fe_data_kept: got %h want a5", bus.data_out); end
      send_frame(8'h81, 1'b1, -1, 1'b0);
      checks++; if (bus.data_out !== 8'h81) begin errors++; $display("FAIL after_fe_data: got %h want 81", bus.data_out); end
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL after_fe_valid: got %b want 1", bus.rx_valid); end
      do_read();
   endtask

   task automatic test_overrun();
      int total_ov;
      send_frame(8'h11, 1'b1, -1, 1'b0);
      total_ov = ov_cnt;
      send_frame(8'h22, 1'b1, -1, 1'b0);
      total_ov += ov_cnt;
      checks++; if (total_ov != 1) begin errors++; $display("FAIL ov_count: got %0d want 1", total_ov); end
      checks++; if (ov_at != STOP_EDGE) begin errors++; $display("FAIL ov_timing: got %0d want %0d", ov_at, STOP_EDGE); end
      checks++; if (bus.data_out !== 8'h22) begin errors++; $display("FAIL ov_data: got %h want 22", bus.data_out); end
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL ov_valid: got %b want 1", bus.rx_valid); end
      do_read();
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL ov_read_clear: got %b want 0", bus.rx_valid); end
   endtask

   task automatic test_back_to_back_read();
      send_frame(8'h33, 1'b1, -1, 1'b0);
      send_frame(8'h44, 1'b1, STOP_EDGE, 1'b0);
      checks++; if (ov_cnt != 0) begin errors++; $display("FAIL collide_ov: got %0d want 0", ov_cnt); end
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL collide_valid: got %b want 1", bus.rx_valid); end
      checks++; if (bus.data_out !== 8'h44) begin errors++; $display("FAIL collide_data: got %h want 44", bus.data_out); end
      do_read();
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      b = 8'hFF;
      for (int c = 0; c < 88; c++) begin
         rx = (c < CPB) ? 1'b0 : b[(c / CPB) - 1];
         @(negedge clk);
      end
      reset_n = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", bus.data_out); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.rx_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      checks++; if ((bus.frame_err !== 1'b0) || (bus.overrun !== 1'b0)) begin errors++; $display("FAIL midrst_pulses: got fe=%b ov=%b want 0 0", bus.frame_err, bus.overrun); end
      idle_cycles(2);
      reset_n = 1'b1;
      idle_cycles(5);
      send_frame(8'h5A, 1'b1, -1, 1'b0);
      checks++; if (bus.data_out !== 8'h5A) begin errors++; $display("FAIL midrst_next_data: got %h want 5a", bus.data_out); end
      checks++; if (valid_rise_at != STOP_EDGE) begin errors++; $display("FAIL midrst_next_timing: got %0d want %0d", valid_rise_at, STOP_EDGE); end
      do_read();
   endtask

`ifdef UART_RX_MAJORITY_EN
   task automatic test_majority();
      send_frame(8'hC3, 1'b1, -1, 1'b1);
      checks++; if (bus.data_out !== 8'hC3) begin errors++; $display("FAIL maj_data: got %h want c3", bus.data_out); end
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL maj_valid: got %b want 1", bus.rx_valid); end
      do_read();
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      idle_cycles(4);
      test_glitch();
      test_frame_err();
      idle_cycles(4);
      test_overrun();
      idle_cycles(4);
      test_back_to_back_read();
      idle_cycles(4);
      test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
      idle_cycles(4);
      test_majority();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
